// File: rtl/eeg_xram_rd_agu.sv
// Strided read-address generator for one XRAM lane, with a 2-entry return buffer
// that forwards the 1-cycle-latency read data (and its last flag) to the consumer.
module eeg_xram_rd_agu #(
    parameter int unsigned XRAM_ADD_AW = 12,
    parameter int unsigned XRAM_DAT_DW = 8,
    parameter int unsigned LEN_DW      = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CMD_VLD,
    output logic                   CMD_RDY,
    input  logic [XRAM_ADD_AW-1:0] CMD_BASE,
    input  logic [LEN_DW-1:0]      CMD_LEN,
    input  logic [XRAM_ADD_AW-1:0] CMD_STRIDE,
    output logic                   XRAM_ADD_VLD,
    output logic                   XRAM_ADD_LST,
    input  logic                   XRAM_ADD_RDY,
    output logic [XRAM_ADD_AW-1:0] XRAM_ADD_ADD,
    input  logic                   XRAM_DAT_VLD,
    input  logic                   XRAM_DAT_LST,
    output logic                   XRAM_DAT_RDY,
    input  logic [XRAM_DAT_DW-1:0] XRAM_DAT_DAT,
    output logic                   OUT_VLD,
    output logic                   OUT_LST,
    input  logic                   OUT_RDY,
    output logic [XRAM_DAT_DW-1:0] OUT_DAT,
    output logic                   BUSY,
    output logic                   DONE
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]             state;
    logic [XRAM_ADD_AW-1:0] addr;
    logic [XRAM_ADD_AW-1:0] stride;
    logic [LEN_DW-1:0]      cnt;
    logic [LEN_DW-1:0]      len;
    logic                   done;

    logic [XRAM_DAT_DW:0]   mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    logic cmd_hs;
    logic add_hs;
    logic push;
    logic pop;

    assign CMD_RDY      = (state == IDLE);
    assign cmd_hs       = CMD_VLD && CMD_RDY;
    assign XRAM_ADD_VLD = (state == ISSUE);
    assign XRAM_ADD_LST = (state == ISSUE) && (cnt == len);
    assign XRAM_ADD_ADD = addr;
    assign add_hs       = XRAM_ADD_VLD && XRAM_ADD_RDY;
    assign BUSY         = (state != IDLE);
    assign DONE         = done;

    // Ready comes only from the registered occupancy, so it never loops back through XRAM.
    assign XRAM_DAT_RDY = (count != 2'd2);
    // Beats seen while idle are leftovers from an aborted burst: accept and drop them.
    assign push         = XRAM_DAT_VLD && XRAM_DAT_RDY && (state != IDLE);
    assign OUT_VLD      = (count != 2'd0);
    assign {OUT_LST, OUT_DAT} = mem[rd_ptr];
    assign pop          = OUT_VLD && OUT_RDY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            stride <= '0;
            cnt    <= '0;
            len    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        len    <= CMD_LEN;
                        stride <= CMD_STRIDE;
                        addr   <= CMD_BASE;
                        cnt    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (add_hs) begin
                        if (XRAM_ADD_LST) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + stride;
                            cnt  <= cnt + LEN_DW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && OUT_LST) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {XRAM_DAT_LST, XRAM_DAT_DAT};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_eeg_xram_rd_agu.sv
// Bench for eeg_xram_rd_agu: a 1-cycle-latency XRAM model plus a burst-level
// reference model that predicts addresses, buffer occupancy, output words and DONE.
module tb_eeg_xram_rd_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [11:0] cmd_base;
    logic [11:0] cmd_len;
    logic [11:0] cmd_stride;
    logic        add_vld;
    logic        add_lst;
    logic        add_rdy;
    logic [11:0] add_add;
    logic        xv;
    logic        xl;
    logic        dat_rdy;
    logic [7:0]  xd;
    logic        out_vld;
    logic        out_lst;
    logic        out_rdy;
    logic [7:0]  out_dat;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    eeg_xram_rd_agu dut (
        .clk          (clk),
        .rst          (rst),
        .CMD_VLD      (cmd_vld),
        .CMD_RDY      (cmd_rdy),
        .CMD_BASE     (cmd_base),
        .CMD_LEN      (cmd_len),
        .CMD_STRIDE   (cmd_stride),
        .XRAM_ADD_VLD (add_vld),
        .XRAM_ADD_LST (add_lst),
        .XRAM_ADD_RDY (add_rdy),
        .XRAM_ADD_ADD (add_add),
        .XRAM_DAT_VLD (xv),
        .XRAM_DAT_LST (xl),
        .XRAM_DAT_RDY (dat_rdy),
        .XRAM_DAT_DAT (xd),
        .OUT_VLD      (out_vld),
        .OUT_LST      (out_lst),
        .OUT_RDY      (out_rdy),
        .OUT_DAT      (out_dat),
        .BUSY         (busy),
        .DONE         (done)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    int errs = 0;
    int chks = 0;
    int cyc  = 0;

    // reference model of one burst
    bit          m_busy;
    bit          m_done;
    int          m_ai;
    int          m_di;
    int          m_len;
    logic [11:0] m_base;
    logic [11:0] m_stride;
    ent_t        m_q[$];

    // stimulus controls and logs
    bit          chk_en;
    bit          cmd_hold;
    bit          out_rand;
    bit          add_rand;
    bit          stall_arm;
    int          stall_left;
    int          ncmd;
    bit          hs_cmd, hs_add, hs_dat, hs_out;
    logic [11:0] s_addr;
    logic        s_lst;
    logic [11:0] addr_log[$];
    logic [7:0]  out_log[$];
    int          t_cmd, t_first_out, busy_cycles;
    bit          seen_first, saw_full, done_at_cmd;

    function automatic logic [7:0] ramf(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    function automatic logic [11:0] exp_addr(input int j);
        return 12'(int'(m_base) + j * int'(m_stride));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit av;
        av = m_busy && (m_ai <= m_len);
        chk("busy", busy, m_busy);
        chk("cmd_rdy", cmd_rdy, !m_busy);
        chk("done", done, m_done);
        chk("out_vld", out_vld, m_q.size() != 0);
        chk("dat_rdy", dat_rdy, m_q.size() < 2);
        chk("add_vld", add_vld, av);
        if (av) begin
            chk("add_addr", add_add, exp_addr(m_ai));
            chk("add_lst", add_lst, m_ai == m_len);
        end
        if (m_q.size() != 0) begin
            chk("out_dat", out_dat, m_q[0].d);
            chk("out_lst", out_lst, m_q[0].l);
        end
        if (busy === 1'b1) busy_cycles++;
        if (dat_rdy === 1'b0) saw_full = 1'b1;
        if (out_vld === 1'b1 && !seen_first) begin
            seen_first  = 1'b1;
            t_first_out = cyc;
        end
    endtask

    task automatic sample_hs();
        hs_cmd = cmd_vld && !m_busy;
        hs_add = m_busy && (m_ai <= m_len) && add_rdy;
        hs_dat = xv && (m_q.size() < 2);
        hs_out = (m_q.size() != 0) && out_rdy;
        s_addr = add_add;
        s_lst  = add_lst;
        if (hs_add) addr_log.push_back(add_add);
        if (hs_out) out_log.push_back(out_dat);
        if (hs_cmd) begin
            t_cmd       = cyc;
            done_at_cmd = done;
        end
    endtask

    task automatic update();
        bit   b0;
        bit   gate;
        ent_t e;
        b0 = m_busy;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q.delete();
            m_ai = 0;
            m_di = 0;
        end else begin
            m_done = 1'b0;
            if (hs_out) begin
                e = m_q.pop_front();
                if (e.l) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
                if (stall_arm) begin
                    stall_arm  = 1'b0;
                    stall_left = 6;
                end
            end
            if (hs_dat && b0) begin
                m_q.push_back('{d: ramf(exp_addr(m_di)), l: (m_di == m_len)});
                m_di++;
            end
            if (hs_add) m_ai++;
            if (hs_cmd) begin
                m_base   = cmd_base;
                m_len    = int'(cmd_len);
                m_stride = cmd_stride;
                m_ai     = 0;
                m_di     = 0;
                m_busy   = 1'b1;
                ncmd++;
                if (!cmd_hold) cmd_vld = 1'b0;
            end
        end
        // XRAM: one registered read port, holds its beat until taken
        if (hs_dat) xv = 1'b0;
        if (hs_add) begin
            xv = 1'b1;
            xd = ramf(s_addr);
            xl = s_lst;
        end
        if (stall_left > 0) begin
            out_rdy = 1'b0;
            stall_left--;
        end else begin
            out_rdy = out_rand ? 1'($urandom % 2) : 1'b1;
        end
        gate    = add_rand ? ($urandom % 4 != 0) : 1'b1;
        add_rdy = gate && (!xv || (m_q.size() < 2));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (chk_en) check_outputs();
        sample_hs();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit && m_busy; k++) step();
        chk("burst_end", m_busy, 1'b0);
    endtask

    task automatic run_burst(input logic [11:0] b, input logic [11:0] l, input logic [11:0] s);
        int n0;
        n0          = ncmd;
        cmd_base    = b;
        cmd_len     = l;
        cmd_stride  = s;
        cmd_vld     = 1'b1;
        addr_log.delete();
        out_log.delete();
        seen_first  = 1'b0;
        busy_cycles = 0;
        saw_full    = 1'b0;
        for (int k = 0; k < 100 && ncmd == n0; k++) step();
        chk("cmd_accept", ncmd, n0 + 1);
        wait_idle((int'(l) + 1) * 40 + 200);
        step();
        step();
    endtask

    initial begin
        logic [11:0] a1[4];
        logic [11:0] a2[4];
        int          n0;

        rst = 1'b1; cmd_vld = 1'b0; cmd_base = '0; cmd_len = '0; cmd_stride = '0;
        add_rdy = 1'b0; out_rdy = 1'b1; xv = 1'b0; xl = 1'b0; xd = '0;
        m_busy = 1'b0; m_done = 1'b0; m_ai = 0; m_di = 0; m_len = 0;
        m_base = '0; m_stride = '0; chk_en = 1'b0; cmd_hold = 1'b0;
        out_rand = 1'b0; add_rand = 1'b0; stall_arm = 1'b0; stall_left = 0; ncmd = 0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_add_add", add_add, 12'h000);
        chk("rst_add_lst", add_lst, 1'b0);
        chk("rst_out_dat", out_dat, 8'h00);
        chk("rst_out_lst", out_lst, 1'b0);
        chk("rst_cmd_rdy", cmd_rdy, 1'b1);
        chk("rst_dat_rdy", dat_rdy, 1'b1);
        rst = 1'b0;
        step();

        // incrementing burst, stall-free
        run_burst(12'h010, 12'd3, 12'd1);
        a1 = '{12'h010, 12'h011, 12'h012, 12'h013};
        chk("b1_naddr", addr_log.size(), 4);
        chk("b1_nout", out_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("b1_addr", addr_log[i], a1[i]);
        for (int i = 0; i < 4 && i < out_log.size(); i++) chk("b1_dat", out_log[i], a1[i][7:0]);
        chk("b1_latency", t_first_out - t_cmd, 3);

        // address wrap with carry dropped
        run_burst(12'hFFE, 12'd3, 12'd1);
        a2 = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        chk("b2_naddr", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("b2_addr", addr_log[i], a2[i]);
        if (out_log.size() > 0) chk("b2_dat0", out_log[0], 8'h01);

        // single-word burst
        run_burst(12'h100, 12'd0, 12'd5);
        chk("b3_naddr", addr_log.size(), 1);
        chk("b3_nout", out_log.size(), 1);
        if (out_log.size() > 0) chk("b3_dat", out_log[0], 8'h11);
        chk("b3_busy_cycles", busy_cycles, 3);

        // consumer stalls for 6 cycles after the first word
        stall_arm = 1'b1;
        run_burst(12'h200, 12'd7, 12'd3);
        chk("b4_nout", out_log.size(), 8);
        chk("b4_saturated", saw_full, 1'b1);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("b4_dat", out_log[i], ramf(12'(12'h200 + 3 * i)));

        // command held valid across two bursts
        cmd_hold = 1'b1; cmd_base = 12'h500; cmd_len = 12'd2; cmd_stride = 12'd7;
        cmd_vld = 1'b1; n0 = ncmd;
        for (int k = 0; k < 400 && ncmd < n0 + 2; k++) step();
        chk("hold_two_cmds", ncmd, n0 + 2);
        chk("hold_cmd_in_done", done_at_cmd, 1'b1);
        cmd_hold = 1'b0; cmd_vld = 1'b0;
        wait_idle(400);
        step();

        // reset after the second address of a 6-word burst
        cmd_base = 12'h300; cmd_len = 12'd5; cmd_stride = 12'd2; cmd_vld = 1'b1; n0 = ncmd;
        for (int k = 0; k < 100 && (ncmd == n0 || m_ai < 2); k++) step();
        chk("rst_mid_addr_cnt", m_ai, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_add_vld", add_vld, 1'b0);
        chk("rst_mid_add_add", add_add, 12'h000);
        chk("rst_mid_out_vld", out_vld, 1'b0);
        chk("rst_mid_out_dat", out_dat, 8'h00);
        chk("rst_mid_done", done, 1'b0);
        step();
        chk("stale_dropped", out_vld, 1'b0);
        step();
        run_burst(12'h040, 12'd1, 12'd1);
        chk("post_rst_nout", out_log.size(), 2);

        // randomized bursts with random back-pressure on both sides
        out_rand = 1'b1;
        add_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_burst(12'($urandom), ($urandom % 8 == 0) ? 12'($urandom % 64) : 12'($urandom % 12),
                      12'($urandom));
            chk("rnd_nout", out_log.size(), m_len + 1);
        end

        // maximum length burst
        out_rand = 1'b0;
        add_rand = 1'b0;
        run_burst(12'($urandom), 12'hFFF, 12'($urandom));
        chk("max_nout", out_log.size(), 4096);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
